// File: rtl/fan_pkg.sv
// fan_pkg: shared CSR map, FSM encoding and tacho decode for the fan controller.
package fan_pkg;
  localparam logic [4:0] OFS_CTRL = 5'd0;
  localparam logic [4:0] OFS_DUTY = 5'd1;
  localparam logic [4:0] OFS_THRESH = 5'd2;
  localparam int CTRL_EN = 0;
  localparam int CTRL_FAIL_EN = 1;
  localparam int CTRL_FAIL = 7;
  localparam logic [7:0] PWM_LAST = 8'd254;
  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_SPINUP = 2'd1,
    ST_RUN = 2'd2,
    ST_FAIL = 2'd3
  } state_t;
  function automatic logic [9:0] tacho_decode(input logic [7:0] v);
    return v[7] ? {v[6:0], 3'b000} : {3'b000, v[6:0]};
  endfunction
endpackage

// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: 255-tick PWM with duty shadowed at each period boundary.
module fan_pwm_gen
  import fan_pkg::*;
#(
  parameter bit PWM_INVERT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_pwm,
  input  logic [7:0] duty_src,
  output logic       pwm_out
);
  logic [7:0] cnt, duty_eff;
  logic wrap;
  assign wrap = ce_pwm && cnt == PWM_LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      duty_eff <= '0;
      pwm_out <= PWM_INVERT;
    end else begin
      if (ce_pwm) cnt <= wrap ? '0 : cnt + 8'd1;
      if (wrap) duty_eff <= duty_src;
      pwm_out <= (cnt < duty_eff) ^ PWM_INVERT;
    end
  end
endmodule

// File: rtl/fan_ctrl.sv
// fan_ctrl: CSR window, spin-up/run/fail FSM with tacho stall detection, drives fan_pwm_gen.
module fan_ctrl
  import fan_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR = 5'h0,
  parameter int SPINUP_SEC = 2,
  parameter int FAIL_SEC = 3,
  parameter bit PWM_INVERT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       ce_1hz,
  input  logic       ce_pwm,
  input  logic [7:0] tacho_val,
  output logic       pwm_out,
  output logic       fan_fail
);
  localparam logic [4:0] A_CTRL = BASE_ADDR + OFS_CTRL;
  localparam logic [4:0] A_DUTY = BASE_ADDR + OFS_DUTY;
  localparam logic [4:0] A_THRESH = BASE_ADDR + OFS_THRESH;
  state_t state, state_nxt;
  logic enable, fail_en, fail_st, ce_q;
  logic [7:0] duty, thresh, duty_src;
  logic [2:0] sec_cnt;
  logic [1:0] low_cnt;
  logic ctrl_wr, en_nxt, clr, low, fail_now;
  assign csr_do = csr_a == A_CTRL ? {fail_st, state, 3'b000, fail_en, enable} :
                  csr_a == A_DUTY ? duty :
                  csr_a == A_THRESH ? thresh : 8'h00;
  assign duty_src = state == ST_OFF ? 8'h00 : state == ST_RUN ? duty : 8'hFF;
  // ce_q marks the evaluation cycle: the tacho value settles one clock after ce_1hz
  always_comb begin
    ctrl_wr = csr_we && csr_a == A_CTRL;
    en_nxt = ctrl_wr ? csr_di[CTRL_EN] : enable;
    clr = ctrl_wr && csr_di[CTRL_FAIL];
    low = tacho_decode(tacho_val) < tacho_decode(thresh);
    fail_now = state == ST_RUN && ce_q && low && low_cnt == 2'(FAIL_SEC - 1);
    state_nxt = state;
    if (!en_nxt) state_nxt = ST_OFF;
    else
      case (state)
        ST_OFF: state_nxt = ST_SPINUP;
        ST_SPINUP: if (ce_q && sec_cnt == 3'(SPINUP_SEC - 1)) state_nxt = ST_RUN;
        ST_RUN: if (fail_now) state_nxt = ST_FAIL;
        default: if (clr) state_nxt = ST_SPINUP;
      endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OFF;
      enable <= 1'b0;
      fail_en <= 1'b0;
      fail_st <= 1'b0;
      duty <= '0;
      thresh <= '0;
      ce_q <= 1'b0;
      sec_cnt <= '0;
      low_cnt <= '0;
      fan_fail <= 1'b0;
    end else begin
      state <= state_nxt;
      ce_q <= ce_1hz;
      enable <= en_nxt;
      if (ctrl_wr) fail_en <= csr_di[CTRL_FAIL_EN];
      if (csr_we && csr_a == A_DUTY) duty <= csr_di;
      if (csr_we && csr_a == A_THRESH) thresh <= csr_di;
      fail_st <= fail_now || (fail_st && !clr);
      sec_cnt <= (state != ST_SPINUP || state_nxt != ST_SPINUP) ? '0 : sec_cnt + {2'b00, ce_q};
      low_cnt <= state != ST_RUN ? '0 : ce_q ? (low ? low_cnt + 2'd1 : '0) : low_cnt;
      fan_fail <= fail_st && fail_en;
    end
  end
  fan_pwm_gen #(.PWM_INVERT(PWM_INVERT)) u_pwm (
    .clk(clk),
    .rst(rst),
    .ce_pwm(ce_pwm),
    .duty_src(duty_src),
    .pwm_out(pwm_out)
  );
endmodule

// File: tb/tb_fan_ctrl.sv
// tb_fan_ctrl: directed bench with a spec-level model checked every cycle, plus literal period/CSR checks.
module tb_fan_ctrl;
  localparam logic [4:0] BASE = 5'h0;
  localparam int SPIN = 2;
  localparam int FSEC = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] csr_a = BASE;
  logic [7:0] csr_di = '0, tacho_val = '0, csr_do, csr_do_i;
  logic csr_we = 1'b0, ce_1hz = 1'b0, ce_pwm = 1'b0;
  logic pwm_out, fan_fail, pwm_inv, fan_fail_i;
  int n_vec = 0, n_bad = 0;
  int m_state = 0, m_duty = 0, m_thr = 0, m_pos = 0, m_deff = 0, m_secs = 0, m_lows = 0;
  logic m_en = 0, m_fen = 0, m_fail = 0, m_pend = 0, m_pwm = 0, m_ff = 0;
  int hi, hi_i;

  always #5 clk = ~clk;

  fan_ctrl #(.BASE_ADDR(BASE), .SPINUP_SEC(SPIN), .FAIL_SEC(FSEC), .PWM_INVERT(1'b0)) dut (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we), .csr_do(csr_do),
    .ce_1hz(ce_1hz), .ce_pwm(ce_pwm), .tacho_val(tacho_val), .pwm_out(pwm_out), .fan_fail(fan_fail));
  fan_ctrl #(.BASE_ADDR(BASE), .SPINUP_SEC(SPIN), .FAIL_SEC(FSEC), .PWM_INVERT(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we), .csr_do(csr_do_i),
    .ce_1hz(ce_1hz), .ce_pwm(ce_pwm), .tacho_val(tacho_val), .pwm_out(pwm_inv), .fan_fail(fan_fail_i));

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [7:0] v);
    return v[7] ? int'(v[6:0]) * 8 : int'(v[6:0]);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [4:0] a);
    if (a == BASE) return {m_fail, 2'(m_state), 3'b000, m_fen, m_en};
    if (a == BASE + 5'd1) return 8'(m_duty);
    if (a == BASE + 5'd2) return 8'(m_thr);
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_state = 0; m_duty = 0; m_thr = 0; m_pos = 0; m_deff = 0; m_secs = 0; m_lows = 0;
    m_en = 0; m_fen = 0; m_fail = 0; m_pend = 0; m_pwm = 0; m_ff = 0;
  endtask

  // One clock of spec behaviour, using the inputs sampled at this edge.
  task automatic model_step();
    logic ev, wr_c, clr, en_n, fail_now;
    int ns;
    m_pwm = m_pos < m_deff;
    m_ff = m_fail & m_fen;
    if (ce_pwm) begin
      if (m_pos == 254) begin
        m_pos = 0;
        m_deff = m_state == 0 ? 0 : m_state == 2 ? m_duty : 255;
      end else m_pos++;
    end
    ev = m_pend;
    m_pend = ce_1hz;
    wr_c = csr_we && csr_a == BASE;
    clr = wr_c && csr_di[7];
    en_n = wr_c ? csr_di[0] : m_en;
    fail_now = m_state == 2 && ev && dec(tacho_val) < dec(8'(m_thr)) && m_lows + 1 >= FSEC;
    ns = m_state;
    if (!en_n) ns = 0;
    else if (m_state == 0) ns = 1;
    else if (m_state == 1 && ev && m_secs + 1 >= SPIN) ns = 2;
    else if (m_state == 2 && fail_now) ns = 3;
    else if (m_state == 3 && clr) ns = 1;
    if (m_state == 1 && ns == 1) m_secs = m_secs + int'(ev); else m_secs = 0;
    if (m_state == 2 && ev) m_lows = dec(tacho_val) < dec(8'(m_thr)) ? m_lows + 1 : 0;
    if (ns != 2) m_lows = 0;
    if (fail_now) m_fail = 1; else if (clr) m_fail = 0;
    if (wr_c) m_fen = csr_di[1];
    m_en = en_n;
    if (csr_we && csr_a == BASE + 5'd1) m_duty = int'(csr_di);
    if (csr_we && csr_a == BASE + 5'd2) m_thr = int'(csr_di);
    m_state = ns;
  endtask

  task automatic cyc(input logic we, input logic [4:0] a, input logic [7:0] di, input logic c1, input logic cp);
    csr_we = we; csr_a = a; csr_di = di; ce_1hz = c1; ce_pwm = cp;
    @(posedge clk);
    model_step();
    #1;
    csr_we = 0; csr_a = BASE; csr_di = '0; ce_1hz = 0; ce_pwm = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cyc(1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic sec_w(input logic [7:0] t, input logic we, input logic [7:0] d);
    tacho_val = t;
    cyc(1'b0, BASE, 8'h00, 1'b1, 1'b0);
    cyc(we, BASE, d, 1'b0, 1'b0);
  endtask

  task automatic sec(input logic [7:0] t);
    sec_w(t, 1'b0, 8'h00);
  endtask

  task automatic align();
    do cyc(1'b0, BASE, 8'h00, 1'b0, 1'b1); while (m_pos != 0);
  endtask

  task automatic period(input int wr_at, input logic [7:0] wv, output int h, output int hv);
    h = 0; hv = 0;
    for (int i = 0; i < 255; i++) begin
      if (i == wr_at) cyc(1'b1, BASE + 5'd1, wv, 1'b0, 1'b1);
      else cyc(1'b0, BASE, 8'h00, 1'b0, 1'b1);
      h += int'(pwm_out);
      hv += int'(pwm_inv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("csr_do", int'(csr_do), int'(exp_rd(csr_a)));
      chk("csr_do_inv", int'(csr_do_i), int'(exp_rd(csr_a)));
      chk("pwm_out", int'(pwm_out), int'(m_pwm));
      chk("pwm_inv", int'(pwm_inv), int'(!m_pwm));
      chk("fan_fail", int'(fan_fail), int'(m_ff));
      chk("fan_fail_inv", int'(fan_fail_i), int'(m_ff));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_pwm_inv", int'(pwm_inv), 1);
    chk("rst_ctrl", int'(csr_do), 8'h00);
    chk("rst_fail", int'(fan_fail), 0);
    #1 rst = 0;
    wr(BASE + 5'd1, 8'h80);
    wr(BASE, 8'h01);
    chk("ctrl_spinup", int'(csr_do), 8'h21);
    align();
    period(-1, 8'h00, hi, hi_i);
    chk("spinup_hi", hi, 255);
    sec(8'h00);
    sec(8'h00);
    chk("ctrl_run", int'(csr_do), 8'h41);
    align();
    period(-1, 8'h00, hi, hi_i);
    chk("duty80_hi", hi, 128);
    chk("duty80_hi_inv", hi_i, 127);
    wr(BASE + 5'd1, 8'h00);
    align();
    period(-1, 8'h00, hi, hi_i);
    chk("duty00_hi", hi, 0);
    chk("duty00_hi_inv", hi_i, 255);
    wr(BASE + 5'd1, 8'hFF);
    align();
    period(-1, 8'h00, hi, hi_i);
    chk("dutyff_hi", hi, 255);
    chk("dutyff_hi_inv", hi_i, 0);
    wr(BASE + 5'd1, 8'h20);
    align();
    period(100, 8'hC0, hi, hi_i);
    chk("duty20_keep", hi, 32);
    period(-1, 8'h00, hi, hi_i);
    chk("dutyc0_next", hi, 192);
    wr(BASE + 5'd2, 8'h0A);
    sec(8'h05);
    sec(8'h05);
    sec(8'h8A);
    sec(8'h05);
    sec(8'h05);
    chk("low_reset_run", int'(csr_do), 8'h41);
    sec(8'h05);
    chk("ctrl_fail", int'(csr_do), 8'hE1);
    chk("fail_masked", int'(fan_fail), 0);
    wr(BASE, 8'h03);
    cyc(1'b0, BASE, 8'h00, 1'b0, 1'b0);
    chk("fail_irq", int'(fan_fail), 1);
    chk("ctrl_fail_en", int'(csr_do), 8'hE3);
    align();
    period(-1, 8'h00, hi, hi_i);
    chk("fail_full", hi, 255);
    wr(BASE, 8'h83);
    chk("clr_spinup", int'(csr_do), 8'h23);
    sec(8'h05);
    sec(8'h05);
    sec(8'h05);
    sec(8'h05);
    sec_w(8'h05, 1'b1, 8'h83);
    chk("fail_wins_clr", int'(csr_do), 8'hE3);
    wr(BASE, 8'h02);
    chk("off_keeps_fail", int'(csr_do), 8'h82);
    cyc(1'b0, BASE, 8'h00, 1'b0, 1'b0);
    chk("off_irq_kept", int'(fan_fail), 1);
    wr(BASE, 8'h80);
    chk("off_cleared", int'(csr_do), 8'h00);
    wr(BASE + 5'd2, 8'h00);
    wr(BASE, 8'h01);
    sec(8'h00);
    sec(8'h00);
    for (int i = 0; i < 4; i++) sec(8'h00);
    chk("thresh0_nofail", int'(csr_do), 8'h41);
    wr(BASE + 5'd2, 8'h0A);
    sec(8'h05);
    sec(8'h05);
    sec_w(8'h05, 1'b1, 8'h00);
    chk("off_and_fail", int'(csr_do), 8'h80);
    wr(BASE, 8'h81);
    wr(BASE + 5'd2, 8'h00);
    wr(BASE + 5'd1, 8'hFF);
    sec(8'h00);
    sec(8'h00);
    align();
    repeat (10) cyc(1'b0, BASE, 8'h00, 1'b0, 1'b1);
    chk("pre_arst_pwm", int'(pwm_out), 1);
    #2 rst = 1;
    #1;
    chk("arst_pwm", int'(pwm_out), 0);
    chk("arst_pwm_inv", int'(pwm_inv), 1);
    chk("arst_ctrl", int'(csr_do), 8'h00);
    model_reset();
    @(negedge clk);
    #1 rst = 0;
    align();
    period(-1, 8'h00, hi, hi_i);
    chk("post_arst_off", hi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fan_ctrl.md
# fan_ctrl

PWM fan controller sitting directly downstream of the tachometer block: it drives the fan PWM pin and consumes the tacho's 1 Hz scaled pulse count for stall detection. Provides a CSR window on the shared 5-bit CPLD register bus, a spin-up phase at full speed after enable, and a fail state that forces 100 % duty and raises an interrupt.

## Interface
- BASE_ADDR, 5'h0, first of three consecutive CSR addresses
- SPINUP_SEC, 2, seconds of forced full duty after enable (1..7)
- FAIL_SEC, 3, consecutive low-tacho seconds before FAIL (1..3)
- PWM_INVERT, 0, 1 = pwm_out active-low
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- csr_a  in  5  CSR address
- csr_di  in  8  CSR write data
- csr_we  in  1  CSR write strobe, one cycle
- csr_do  out  8  CSR read data, 0 when address not ours (combinational)
- ce_1hz  in  1  one-cycle 1 Hz enable, same pulse the tacho block uses
- ce_pwm  in  1  PWM tick enable
- tacho_val  in  8  tacho reading {scale, count[6:0]}
- pwm_out  out  1  fan PWM, registered
- fan_fail  out  1  interrupt, level, registered

## Operation
- Registers: BASE+0 CTRL: [0] enable, [1] fail_en, [6:5] state (RO), [7] fail status (RO, write 1 clears); BASE+1 DUTY: target duty 0..255; BASE+2 THRESH: minimum tacho, same {scale,count} encoding. All reset to 0.
- Decode: value10 = scale ? {count,3'b0} : {3'b0,count}; applied to tacho_val and THRESH; compare unsigned 10-bit.
- PWM: 8-bit counter advances on ce_pwm, 0..254 then wraps to 0 (period 255 ticks). Raw output = counter < duty_eff; duty 0 = always low, 255 = always high. duty_eff loaded from its source only when counter wraps to 0 (and at reset, value 0).
- duty source: OFF → 0; SPINUP, FAIL → 255; RUN → DUTY.
- FSM: OFF (2'd0), SPINUP (1), RUN (2), FAIL (3).
  - OFF → SPINUP when enable written 1; seconds counter cleared.
  - SPINUP → RUN after SPINUP_SEC ce_1hz pulses; no evaluation in SPINUP.
  - RUN: on each evaluation, value10(tacho_val) < value10(THRESH) increments low counter, else clears it; reaching FAIL_SEC → FAIL, fail status set.
  - FAIL → SPINUP when fail status cleared by write; failure counter cleared.
  - Any state → OFF when enable = 0; fail status kept.
- fan_fail = fail status & fail_en.
- THRESH = 0 never fails.

## Timing
- Evaluation occurs in the cycle after ce_1hz (ce_1hz registered once), because the tacho value updates one clock after ce_1hz.
- CSR write effective next cycle; read reflects registers combinationally.
- pwm_out, fan_fail registered: one cycle after internal change. Reset: pwm_out = PWM_INVERT, fan_fail = 0, state OFF.
- Simultaneous: new failure and W1C clear same cycle → failure wins (status stays 1, state FAIL). Enable cleared and failure same cycle → OFF, status set. DUTY write in SPINUP/FAIL stored, used on entry to RUN at next period boundary.
- Async reset mid-period: counter, duty_eff, FSM to reset values immediately.

## Structure
- Shared package fan_pkg: register offsets (CTRL, DUTY, THRESH), state encoding, CTRL bit positions, tacho decode function (also usable by tacho block consumers).
- Sub-module fan_pwm_gen: counter, shadow duty load, compare, inversion; fan_ctrl holds CSR, FSM, timers.

## Test plan
- Reset, DUTY=8'h80, enable: 2 ce_1hz at full duty (SPINUP), then RUN; pwm_out high exactly 128 of 255 ce_pwm ticks per period.
- DUTY 0 and 255 in RUN: pwm_out constant 0 / constant 1; PWM_INVERT=1 inverts both.
- THRESH=8'h0A, tacho_val=8'h05 for 3 evaluations → state 3, CTRL[7]=1, pwm full; fan_fail=1 only when fail_en=1.
- Low for 2 s, then 8'h8A (decoded 80) once, then low 2 s → no FAIL (counter reset).
- Write CTRL 8'h83 in FAIL → SPINUP; write coinciding with third low evaluation → status remains 1.
- DUTY changed mid-period from 8'h20 to 8'hC0 → current period keeps 32 high ticks, next period 192.
